// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave byte controller.
package i2c_slave_pkg;

    localparam int         BYTE_BITS = 8;
    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_DATA,
        RX_ACK,
        TX_DATA,
        TX_ACK,
        WAIT_STOP
    } state_e;

endpackage

// File: rtl/i2c_slave_bit_counter.sv
// 3-bit count-down bit counter: load to 7, decrement on enable, zero flag.
module i2c_slave_bit_counter
    import i2c_slave_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    output logic [2:0] cnt,
    output logic       zero
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)     cnt_d = 3'(BYTE_BITS - 1);
        else if (dec) cnt_d = cnt_q - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 3'd0;
        else     cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == 3'd0);

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C slave: oversampled SCL/SDA, START/STOP detect, address match,
// ACK/shift FSM. Optional clock stretching with I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave_byte_ctrl
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Scl_i,
    input  logic       Sda_i,
    output logic       Sda_oe,
    output logic       Scl_oe,
    output logic [7:0] Rx_data,
    output logic       Rx_valid,
    input  logic [7:0] Tx_data,
    input  logic       Tx_valid,
    output logic       Tx_ready,
    output logic       Rw,
    output logic       Busy,
    output logic       Nack_rx
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic scl_s, sda_s, scl_h_q, sda_h_q;
    logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic start_q, start_d, stop_q, stop_d, sda_smp_q, sda_smp_d;

    state_e               state_q, state_d;
    logic [BYTE_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d, tx_byte;
    logic rw_q, rw_d, busy_q, busy_d, sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
    logic rx_pend_q, rx_pend_d, rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
    logic nack_q, nack_d, ph_q, ph_d, stall_q, stall_d;
    logic cnt_load, cnt_dec, cnt_zero, tx_go;
    logic [2:0] cnt;

    i2c_slave_bit_counter u_bit_cnt (
        .clk  (Clk),
        .rst  (Rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .cnt  (cnt),
        .zero (cnt_zero)
    );

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], Scl_i};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], Sda_i};
    assign tx_byte    = Tx_valid ? Tx_data : IDLE_BYTE;

    // Edge/condition pulses are registered; sda_smp holds SDA as seen at the SCL edge.
    always_comb begin
        scl_rise_d = scl_s & ~scl_h_q;
        scl_fall_d = ~scl_s & scl_h_q;
        start_d    = scl_s & scl_h_q & sda_h_q & ~sda_s;
        stop_d     = scl_s & scl_h_q & ~sda_h_q & sda_s;
        sda_smp_d  = sda_s;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;
        scl_oe_d   = scl_oe_q;
        ph_d       = ph_q;
        stall_d    = stall_q;
        rx_pend_d  = 1'b0;
        rx_valid_d = rx_pend_q;
        tx_ready_d = 1'b0;
        nack_d     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        tx_go      = 1'b0;
        if (start_q) begin
            state_d  = ADDR;
            cnt_load = 1'b1;
            busy_d   = 1'b1;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
            ph_d     = 1'b0;
            stall_d  = 1'b0;
            shift_d  = '0;
        end else if (stop_q) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
            ph_d     = 1'b0;
            stall_d  = 1'b0;
        end else begin
            // SCL is let go one cycle after the stalled byte has been loaded.
            if (scl_oe_q && !stall_q) scl_oe_d = 1'b0;
            case (state_q)
                ADDR: if (scl_rise_q) begin
                    cnt_dec = 1'b1;
                    shift_d = {shift_q[6:0], sda_smp_q};
                    if (cnt_zero) begin
                        if (shift_q[6:0] == SLAVE_ADDR) begin
                            rw_d    = sda_smp_q;
                            ph_d    = 1'b0;
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK, RX_ACK: begin
                    if (stall_q) tx_go = Tx_valid;
                    else if (scl_fall_q) begin
                        if (!ph_q) begin
                            sda_oe_d = 1'b1;
                            ph_d     = 1'b1;
                        end else begin
                            ph_d     = 1'b0;
                            sda_oe_d = 1'b0;
                            if (state_q == ADDR_ACK && rw_q) tx_go = 1'b1;
                            else begin
                                state_d  = RX_DATA;
                                cnt_load = 1'b1;
                            end
                        end
                    end
                end
                RX_DATA: if (scl_rise_q) begin
                    cnt_dec = 1'b1;
                    shift_d = {shift_q[6:0], sda_smp_q};
                    if (cnt_zero) begin
                        rx_data_d = {shift_q[6:0], sda_smp_q};
                        rx_pend_d = 1'b1;
                        ph_d      = 1'b0;
                        state_d   = RX_ACK;
                    end
                end
                TX_DATA: begin
                    if (scl_rise_q) begin
                        cnt_dec = 1'b1;
                        if (cnt_zero) ph_d = 1'b1;
                    end else if (scl_fall_q) begin
                        if (ph_q) begin
                            sda_oe_d = 1'b0;
                            ph_d     = 1'b0;
                            state_d  = TX_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                TX_ACK: begin
                    if (stall_q) tx_go = Tx_valid;
                    else if (scl_rise_q) begin
                        if (!sda_smp_q) ph_d = 1'b1;
                        else begin
                            nack_d  = 1'b1;
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall_q && ph_q) begin
                        ph_d  = 1'b0;
                        tx_go = 1'b1;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
            // Load the next read byte and drive its MSB on the same SCL low phase.
            if (tx_go) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                if (!Tx_valid) begin
                    stall_d  = 1'b1;
                    scl_oe_d = 1'b1;
                end else
`endif
                begin
                    state_d    = TX_DATA;
                    cnt_load   = 1'b1;
                    stall_d    = 1'b0;
                    tx_ready_d = Tx_valid;
                    sda_oe_d   = ~tx_byte[7];
                    shift_d    = {tx_byte[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_h_q    <= 1'b1;
            sda_h_q    <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_smp_q  <= 1'b1;
            state_q    <= IDLE;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            ph_q       <= 1'b0;
            stall_q    <= 1'b0;
            rx_pend_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_h_q    <= scl_s;
            sda_h_q    <= sda_s;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            sda_smp_q  <= sda_smp_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            ph_q       <= ph_d;
            stall_q    <= stall_d;
            rx_pend_q  <= rx_pend_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            nack_q     <= nack_d;
        end
    end

    assign Sda_oe   = sda_oe_q;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    assign Scl_oe   = scl_oe_q;
`else
    assign Scl_oe   = 1'b0;
`endif
    assign Rx_data  = rx_data_q;
    assign Rx_valid = rx_valid_q;
    assign Tx_ready = tx_ready_q;
    assign Rw       = rw_q;
    assign Busy     = busy_q;
    assign Nack_rx  = nack_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Directed bench: bit-banged I2C master on an open-drain bus model around the slave.
module tb_i2c_slave_byte_ctrl;

    localparam int Q = 10;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       m_scl = 1'b1, m_sda = 1'b1;
    logic       Scl_i, Sda_i, Sda_oe, Scl_oe;
    logic [7:0] Rx_data, Tx_data;
    logic       Rx_valid, Tx_valid, Tx_ready, Rw, Busy, Nack_rx;

    int errors = 0;
    int checks = 0;
    int rx_pulses = 0, tx_pulses = 0, nack_pulses = 0, sda_oe_cyc = 0, scl_oe_cyc = 0;
    logic [7:0] rx_last = 8'h00;

    assign Scl_i = m_scl & ~Scl_oe;
    assign Sda_i = m_sda & ~Sda_oe;

    always #5 Clk = ~Clk;

    i2c_slave_byte_ctrl #(.SLAVE_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
        .Clk(Clk), .Rst(Rst), .Scl_i(Scl_i), .Sda_i(Sda_i), .Sda_oe(Sda_oe), .Scl_oe(Scl_oe),
        .Rx_data(Rx_data), .Rx_valid(Rx_valid), .Tx_data(Tx_data), .Tx_valid(Tx_valid),
        .Tx_ready(Tx_ready), .Rw(Rw), .Busy(Busy), .Nack_rx(Nack_rx)
    );

    always @(negedge Clk) begin
        if (Rx_valid) begin rx_pulses++; rx_last = Rx_data; end
        if (Tx_ready) tx_pulses++;
        if (Nack_rx)  nack_pulses++;
        if (Sda_oe)   sda_oe_cyc++;
        if (Scl_oe)   scl_oe_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge Clk);
    endtask

    task automatic scl_high();
        int n;
        m_scl = 1'b1;
        n = 0;
        while (Scl_i !== 1'b1 && n < 1000) begin @(negedge Clk); n++; end
        if (n >= 1000) begin
            checks++; errors++;
            $error("FAIL scl_release: observed=held_low expected=released");
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wq(); scl_high(); wq();
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq(); scl_high(); wq();
        m_sda = 1'b1; wq();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wq(); scl_high(); wq(); wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wq(); scl_high(); wq();
        b = Sda_i; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack_bit, input logic [7:0] next_tx, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin read_bit(b); d[i] = b; end
        Tx_data = next_tx;
        write_bit(ack_bit);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int rx0, tx0, nk0, oe0, so0;
        Tx_data = 8'h5A; Tx_valid = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk("reset_outputs", {Sda_oe, Scl_oe, Rx_data, Rx_valid, Tx_ready, Rw, Busy, Nack_rx}, 32'h0);

        // Write 0xA5 to our address
        rx0 = rx_pulses;
        i2c_start();
        chk("wr_busy_after_start", Busy, 1'b1);
        write_byte(8'h78, ack);  chk("wr_addr_ack", ack, 1'b0);
        chk("wr_rw", Rw, 1'b0);
        write_byte(8'hA5, ack);  chk("wr_data_ack", ack, 1'b0);
        i2c_stop();
        chk("wr_rx_pulses", rx_pulses - rx0, 1);
        chk("wr_rx_last", rx_last, 8'hA5);
        chk("wr_rx_data", Rx_data, 8'hA5);
        chk("wr_busy_after_stop", Busy, 1'b0);

        // Address mismatch: no ACK, no data
        rx0 = rx_pulses; oe0 = sda_oe_cyc;
        i2c_start();
        write_byte(8'h7A, ack);  chk("mis_addr_nack", ack, 1'b1);
        write_byte(8'h11, ack);  chk("mis_data_nack", ack, 1'b1);
        chk("mis_busy_wait_stop", Busy, 1'b1);
        i2c_stop();
        chk("mis_sda_oe_cycles", sda_oe_cyc - oe0, 0);
        chk("mis_rx_pulses", rx_pulses - rx0, 0);
        chk("mis_busy_after_stop", Busy, 1'b0);

        // Read two bytes, ACK then NACK
        tx0 = tx_pulses; nk0 = nack_pulses; Tx_data = 8'h5A;
        i2c_start();
        write_byte(8'h79, ack);  chk("rd_addr_ack", ack, 1'b0);
        chk("rd_rw", Rw, 1'b1);
        read_byte(1'b0, 8'hC3, rd); chk("rd_byte1", rd, 8'h5A);
        read_byte(1'b1, 8'h00, rd); chk("rd_byte2", rd, 8'hC3);
        chk("rd_nack_pulses", nack_pulses - nk0, 1);
        i2c_stop();
        chk("rd_tx_ready_pulses", tx_pulses - tx0, 2);

        // Repeated START from write into read
        rx0 = rx_pulses; Tx_data = 8'h96;
        i2c_start();
        write_byte(8'h78, ack);  chk("sr_addr_w_ack", ack, 1'b0);
        write_byte(8'h0F, ack);  chk("sr_data_ack", ack, 1'b0);
        i2c_start();
        chk("sr_busy", Busy, 1'b1);
        write_byte(8'h79, ack);  chk("sr_addr_r_ack", ack, 1'b0);
        chk("sr_rw", Rw, 1'b1);
        read_byte(1'b1, 8'h00, rd); chk("sr_read", rd, 8'h96);
        i2c_stop();
        chk("sr_rx_pulses", rx_pulses - rx0, 1);
        chk("sr_rx_last", rx_last, 8'h0F);

        // Reset after 4 data bits, then a clean write
        i2c_start();
        write_byte(8'h78, ack);  chk("rst_addr_ack", ack, 1'b0);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        chk("rst_busy_before", Busy, 1'b1);
        Rst = 1'b1;
        @(negedge Clk);
        chk("rst_outputs", {Sda_oe, Scl_oe, Rx_data, Rx_valid, Tx_ready, Rw, Busy, Nack_rx}, 32'h0);
        Rst = 1'b0;
        i2c_stop();
        rx0 = rx_pulses;
        i2c_start();
        write_byte(8'h78, ack);  chk("post_rst_addr_ack", ack, 1'b0);
        write_byte(8'h5C, ack);  chk("post_rst_data_ack", ack, 1'b0);
        i2c_stop();
        chk("post_rst_rx_pulses", rx_pulses - rx0, 1);
        chk("post_rst_rx_data", Rx_data, 8'h5C);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
        // Tx_valid low after the address ACK: slave holds SCL until data arrives
        Tx_valid = 1'b0; so0 = scl_oe_cyc;
        i2c_start();
        write_byte(8'h79, ack);  chk("st_addr_ack", ack, 1'b0);
        fork
            read_byte(1'b1, 8'hE7, rd);
            begin
                int n;
                n = 0;
                while (Scl_oe !== 1'b1 && n < 2000) begin @(negedge Clk); n++; end
                repeat (50) @(negedge Clk);
                Tx_data = 8'hE7; Tx_valid = 1'b1;
            end
        join
        chk("st_read", rd, 8'hE7);
        chk("st_scl_oe_cycles_50_to_53",
            32'((scl_oe_cyc - so0) >= 50 && (scl_oe_cyc - so0) <= 53), 32'h1);
        i2c_stop();
        chk("st_scl_released", Scl_oe, 1'b0);
`else
        so0 = 0;
        chk("scl_oe_never", scl_oe_cyc - so0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_byte_ctrl.md
Name: i2c_slave_byte_ctrl

Overview:
- Byte-level I2C slave (responder) controller; the target-side counterpart of the I2C master byte/bit controller.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches the 7-bit address, ACKs write bytes and shifts out read bytes.
- Exposes a simple valid/ready byte interface to the register file or user logic. Sits between the open-drain pad buffers and the slave register bank.

Parameters:
- SLAVE_ADDR, 7'h3C, 7-bit address this slave responds to.
- SYNC_STAGES, 2, synchronizer flops on Scl_i/Sda_i (minimum 2).

Ports:
- Clk  in  1  system clock; must be at least 16x the SCL frequency.
- Rst  in  1  synchronous active-high reset.
- Scl_i  in  1  SCL pad input (asynchronous).
- Sda_i  in  1  SDA pad input (asynchronous).
- Sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- Scl_oe  out  1  1 = pull SCL low (clock stretch). Tied 0 without the optional feature.
- Rx_data  out  8  last byte received in a write transfer.
- Rx_valid  out  1  1-cycle pulse; Rx_data is valid.
- Tx_data  in  8  byte to send in a read transfer.
- Tx_valid  in  1  Tx_data available.
- Tx_ready  out  1  1-cycle pulse; Tx_data captured into the shifter.
- Rw  out  1  R/W bit of the current transfer (1 = read).
- Busy  out  1  1 from START detection to STOP detection.
- Nack_rx  out  1  1-cycle pulse; master NACKed a read byte.

Behaviour:
- Reset state: all outputs 0. FSM is in IDLE; shifter and bit counter are 0.
- Input conditioning:
  - SYNC_STAGES flops, then one history flop per line.
  - Edge detect (scl_rise, scl_fall) is registered. Latency from pad to edge pulse is SYNC_STAGES+1 cycles.
- START: SDA falls while SCL high. Recognised in any state, including mid-byte (repeated START). Sets Busy and enters ADDR with bit counter = 7.
- STOP: SDA rises while SCL high. Recognised in any state. Clears Busy and Sda_oe and returns to IDLE. No Rx_valid is issued for a partial byte.
- Bit counter: 3-bit count-down.
  - Loaded to 7 on entry to ADDR, RX_DATA or TX_DATA.
  - Decrements on each scl_rise.
  - Counter == 0 at scl_rise marks the 8th bit. No wrap is observable because reload always precedes reuse.
- Sampling and driving:
  - RX shifter samples SDA MSB-first on scl_rise.
  - SDA changes (Sda_oe) only on scl_fall.
- FSM states and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - At the 8th scl_rise compare bits[7:1] with SLAVE_ADDR.
    - Match: latch Rw = bit0 and go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP with Sda_oe held 0.
  - ADDR_ACK: assert Sda_oe on the next scl_fall and hold through the ACK high phase. Release on the following scl_fall, then:
    - Rw=0: go to RX_DATA.
    - Rw=1: go to TX_DATA, capturing Tx_data and pulsing Tx_ready on that scl_fall.
      - If Tx_valid=0 at that moment, 8'hFF is sent.
  - RX_DATA: shift 8 bits. At the 8th scl_rise:
    - Rx_data updates.
    - Rx_valid pulses on the next cycle.
    - Go to RX_ACK.
  - RX_ACK: ACK driven exactly as in ADDR_ACK, then back to RX_DATA.
  - TX_DATA: drive Sda_oe = ~shifter[7] on each scl_fall, then shift left. After the 8th bit, release SDA on scl_fall and go to TX_ACK.
  - TX_ACK: sample SDA on scl_rise.
    - SDA=0 (ACK): go to TX_DATA; the next byte is captured and Tx_ready pulses on scl_fall.
    - SDA=1 (NACK): pulse Nack_rx and go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- Simultaneous events:
  - START/STOP detection has priority over any scl edge in the same cycle.
  - Rst has priority over everything.
- Reset mid-transfer releases SDA/SCL within 1 cycle. A transfer in progress is ignored until the next START.

Optional Feature:
- Macro: I2C_SLAVE_CLK_STRETCH_EN.
- Defined:
  - In ADDR_ACK (Rw=1) or TX_ACK with ACK, if Tx_valid=0 at scl_fall, Scl_oe asserts and the FSM holds.
  - When Tx_valid rises, Tx_data is captured, Tx_ready pulses and Scl_oe releases on the next cycle.
  - The first data bit is placed on SDA before the release.
- Undefined: Scl_oe is constant 0, no stretching, and the 8'hFF substitution applies.

Decomposition:
- Package i2c_slave_pkg: FSM state encodings (IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP), BYTE_BITS=8, IDLE_BYTE=8'hFF.
- Sub-module: i2c_slave_bit_counter. Load-to-7, decrement-on-enable, zero flag; synchronous active-high reset.

Test Plan:
- Write, address match: START, 0x78 (0x3C, W), data 0xA5, STOP -> ACK low on both 9th bits; Rx_valid pulses once with Rx_data=0xA5; Busy deasserts after STOP.
- Address mismatch: START, 0x7A, data 0x11 -> Sda_oe never asserts; no Rx_valid; FSM in WAIT_STOP until STOP.
- Read two bytes: START, 0x79, master ACKs byte 1 and NACKs byte 2, Tx_data 0x5A then 0xC3 -> SDA carries 0x5A then 0xC3 MSB-first; two Tx_ready pulses; one Nack_rx pulse.
- Repeated START: START, 0x78, data 0x0F, Sr, 0x79 -> Rx_valid for 0x0F; Rw=1 after Sr; the read proceeds normally.
- Reset mid-byte: assert Rst after 4 data bits of a write -> all outputs 0 next cycle; the following full transaction succeeds.
- Stretch (macro defined): read with Tx_valid=0 for 50 cycles after the address ACK -> Scl_oe high for those cycles; releases 1 cycle after Tx_valid; byte sent correctly.
